// File: rtl/fighter_pkg.sv
// Shared fighter definitions: FSM state codes, RGB332 colours and playfield defaults
// used by the motion controller, the fighter FSM and the VGA compositor.
package fighter_pkg;

    localparam int SCREEN_WIDTH_DEF = 640;
    localparam int SPRITE_WIDTH_DEF = 64;

    localparam logic [3:0] ST_IDLE         = 4'd0;
    localparam logic [3:0] ST_BACKWARD     = 4'd1;
    localparam logic [3:0] ST_FORWARD      = 4'd2;
    localparam logic [3:0] ST_LP_STARTUP   = 4'd3;
    localparam logic [3:0] ST_LP_ACTIVE    = 4'd4;
    localparam logic [3:0] ST_LP_RECOVERY  = 4'd5;
    localparam logic [3:0] ST_HP_STARTUP   = 4'd6;
    localparam logic [3:0] ST_HP_ACTIVE    = 4'd7;
    localparam logic [3:0] ST_HP_RECOVERY  = 4'd8;
    localparam logic [3:0] ST_HITSTUN      = 4'd9;
    localparam logic [3:0] ST_BLOCKSTUN    = 4'd10;

    localparam logic [7:0] COL_BLACK  = 8'h00;
    localparam logic [7:0] COL_YELLOW = 8'hFC;
    localparam logic [7:0] COL_RED    = 8'hE0;
    localparam logic [7:0] COL_GREEN  = 8'h1C;
    localparam logic [7:0] COL_PURPLE = 8'h88;
    localparam logic [7:0] COL_PINK   = 8'h0F;
    localparam logic [7:0] COL_WHITE  = 8'hFF;

    typedef enum logic {
        KB_IDLE,
        KB_PUSH
    } kb_state_t;

    function automatic logic is_stun(input logic [3:0] s);
        return (s == ST_HITSTUN) || (s == ST_BLOCKSTUN);
    endfunction

    function automatic logic [7:0] state_color(input logic [3:0] s);
        logic [7:0] c;
        case (s)
            ST_IDLE, ST_BACKWARD, ST_FORWARD: c = COL_BLACK;
            ST_LP_STARTUP, ST_HP_STARTUP:     c = COL_YELLOW;
            ST_LP_ACTIVE, ST_HP_ACTIVE:       c = COL_RED;
            ST_LP_RECOVERY, ST_HP_RECOVERY:   c = COL_GREEN;
            ST_HITSTUN:                       c = COL_PURPLE;
            ST_BLOCKSTUN:                     c = COL_PINK;
            default:                          c = COL_WHITE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fighter_x_clamp.sv
// Combinational x-target calculator: applies a signed delta, stops forward motion
// where the sprites abut, and clamps the result to the screen walls.
module fighter_x_clamp import fighter_pkg::*; #(
    parameter int IS_MIRRORED  = 0,
    parameter int SCREEN_WIDTH = SCREEN_WIDTH_DEF,
    parameter int SPRITE_WIDTH = SPRITE_WIDTH_DEF
) (
    input  logic [9:0]        x,
    input  logic signed [10:0] delta,
    input  logic [9:0]        opponent_x,
    input  logic              forward,
    output logic [9:0]        target
);

    localparam logic signed [11:0] RIGHT_LIM = 12'(SCREEN_WIDTH - SPRITE_WIDTH);
    localparam logic signed [11:0] SW        = 12'(SPRITE_WIDTH);

    logic signed [11:0] xs, opp, raw, lim, lim_t, walled;

    always_comb begin
        xs    = $signed({2'b00, x});
        opp   = $signed({2'b00, opponent_x});
        raw   = xs + $signed({delta[10], delta});
        lim   = (IS_MIRRORED != 0) ? opp + SW : opp - SW;
        lim_t = raw;
        // A fighter already overlapping the opponent holds rather than snapping back.
        if (forward) begin
            if (IS_MIRRORED != 0) begin
                if (xs <= lim)       lim_t = xs;
                else if (raw < lim)  lim_t = lim;
            end else begin
                if (xs >= lim)       lim_t = xs;
                else if (raw > lim)  lim_t = lim;
            end
        end
        if (lim_t < 12'sd0)          walled = 12'sd0;
        else if (lim_t > RIGHT_LIM)  walled = RIGHT_LIM;
        else                         walled = lim_t;
        target = 10'(walled);
    end

endmodule

// File: rtl/fighter_motion.sv
// Per-fighter position controller: frame-paced walking, wall/opponent clamping and
// a timed knockback push entered on hitstun or blockstun.
module fighter_motion import fighter_pkg::*; #(
    parameter int IS_MIRRORED    = 0,
    parameter int SCREEN_WIDTH   = SCREEN_WIDTH_DEF,
    parameter int SPRITE_WIDTH   = SPRITE_WIDTH_DEF,
    parameter int SPRITE_Y       = 180,
    parameter int START_MARGIN   = 100,
    parameter int FWD_SPEED      = 3,
    parameter int BACK_SPEED     = 2,
    parameter int KB_HIT_SPEED   = 4,
    parameter int KB_BLOCK_SPEED = 2,
    parameter int KB_FRAMES      = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [3:0] state,
    input  logic [9:0] opponent_x,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic [7:0] sprite_color,
    output logic       in_knockback,
    output logic       at_wall
);

    localparam int         RIGHT_LIM = SCREEN_WIDTH - SPRITE_WIDTH;
    localparam logic [9:0] L_LIM     = 10'd0;
    localparam logic [9:0] R_LIM     = 10'(RIGHT_LIM);
    localparam logic [9:0] RESET_X   = 10'((IS_MIRRORED != 0) ? RIGHT_LIM - START_MARGIN : START_MARGIN);
    localparam logic [9:0] Y_POS     = 10'(SPRITE_Y);
    localparam logic [9:0] FWD_SPD   = 10'(FWD_SPEED);
    localparam logic [9:0] BACK_SPD  = 10'(BACK_SPEED);
    localparam logic [9:0] HIT_SPD   = 10'(KB_HIT_SPEED);
    localparam logic [9:0] BLOCK_SPD = 10'(KB_BLOCK_SPEED);
    localparam logic [3:0] KB_LOAD   = 4'(KB_FRAMES);

    kb_state_t         kb_state, kb_next;
    logic [3:0]        kb_cnt, kb_cnt_next, prev_state;
    logic [9:0]        kb_speed, speed_next, move_spd, target;
    logic              stun_entry, move_fwd, move_away;
    logic signed [10:0] delta;

    always_comb begin
        stun_entry  = is_stun(state) && !is_stun(prev_state);
        speed_next  = kb_speed;
        kb_cnt_next = kb_cnt;
        kb_next     = kb_state;
        move_spd    = '0;
        move_fwd    = 1'b0;
        move_away   = 1'b0;
        // The entry tick already moves, so the counter is loaded and consumed at once.
        if (stun_entry) begin
            speed_next  = (state == ST_HITSTUN) ? HIT_SPD : BLOCK_SPD;
            kb_cnt_next = KB_LOAD - 4'd1;
            move_spd    = speed_next;
            move_away   = 1'b1;
        end else if (kb_state == KB_PUSH) begin
            kb_cnt_next = kb_cnt - 4'd1;
            move_spd    = kb_speed;
            move_away   = 1'b1;
        end else if (state == ST_FORWARD) begin
            move_spd = FWD_SPD;
            move_fwd = 1'b1;
        end else if (state == ST_BACKWARD) begin
            move_spd  = BACK_SPD;
            move_away = 1'b1;
        end
        if (stun_entry || kb_state == KB_PUSH)
            kb_next = (kb_cnt_next == 4'd0) ? KB_IDLE : KB_PUSH;
        // Away is +x for a mirrored fighter, forward is +x for an unmirrored one.
        delta = (((IS_MIRRORED != 0) ? 1'b1 : 1'b0) == move_away)
              ? $signed({1'b0, move_spd}) : -$signed({1'b0, move_spd});
    end

    fighter_x_clamp #(
        .IS_MIRRORED  (IS_MIRRORED),
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .SPRITE_WIDTH (SPRITE_WIDTH)
    ) u_clamp (
        .x          (sprite_x),
        .delta      (delta),
        .opponent_x (opponent_x),
        .forward    (move_fwd),
        .target     (target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sprite_x     <= RESET_X;
            sprite_y     <= Y_POS;
            sprite_color <= COL_BLACK;
            in_knockback <= 1'b0;
            at_wall      <= 1'b0;
            kb_state     <= KB_IDLE;
            kb_cnt       <= 4'd0;
            kb_speed     <= '0;
            prev_state   <= ST_IDLE;
        end else begin
            sprite_y     <= Y_POS;
            sprite_color <= state_color(state);
            at_wall      <= (sprite_x == L_LIM) || (sprite_x == R_LIM);
            if (frame_tick) begin
                sprite_x     <= target;
                prev_state   <= state;
                kb_state     <= kb_next;
                kb_cnt       <= kb_cnt_next;
                kb_speed     <= speed_next;
                in_knockback <= (kb_next == KB_PUSH);
            end
        end
    end

endmodule

// File: tb/tb_fighter_motion.sv
// Bench for fighter_motion: unmirrored and mirrored instances checked every cycle
// against a behavioural model, plus directed scenarios with literal expectations.
module tb_fighter_motion;

    localparam int RL = 576;
    localparam int KB = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [3:0] st [2];
    logic [9:0] opp [2];
    logic [9:0] sx [2];
    logic [9:0] sy [2];
    logic [7:0] col [2];
    logic       kb [2];
    logic       wall [2];

    int errors = 0;
    int checks = 0;

    int m_x [2]   = '{100, 476};
    int m_prev [2] = '{0, 0};
    int m_left [2] = '{0, 0};
    int m_spd [2]  = '{0, 0};
    int m_col [2]  = '{0, 0};
    int m_wall [2] = '{0, 0};
    int m_kb [2]   = '{0, 0};
    int col_tab [16] = '{'h00, 'h00, 'h00, 'hFC, 'hE0, 'h1C, 'hFC, 'hE0,
                         'h1C, 'h88, 'h0F, 'hFF, 'hFF, 'hFF, 'hFF, 'hFF};

    always #5 clk = ~clk;

    fighter_motion #(.IS_MIRRORED(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .state(st[0]),
        .opponent_x(opp[0]), .sprite_x(sx[0]), .sprite_y(sy[0]),
        .sprite_color(col[0]), .in_knockback(kb[0]), .at_wall(wall[0])
    );

    fighter_motion #(.IS_MIRRORED(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .state(st[1]),
        .opponent_x(opp[1]), .sprite_x(sx[1]), .sprite_y(sy[1]),
        .sprite_color(col[1]), .in_knockback(kb[1]), .at_wall(wall[1])
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_wall(input int v);
        return (v < 0) ? 0 : ((v > RL) ? RL : v);
    endfunction

    // Forward step: stop where the sprites touch; never pull back an overlapping fighter.
    function automatic int fwd_step(input int i, input int x, input int o);
        int lim;
        if (i == 0) begin
            lim = o - 64;
            return (x >= lim) ? x : to_wall((x + 3 < lim) ? x + 3 : lim);
        end
        lim = o + 64;
        return (x <= lim) ? x : to_wall((x - 3 > lim) ? x - 3 : lim);
    endfunction

    // Behavioural reference
    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_x[i] = (i == 0) ? 100 : 476;
                m_prev[i] = 0; m_left[i] = 0; m_spd[i] = 0;
                m_col[i] = 0; m_wall[i] = 0; m_kb[i] = 0;
            end else begin
                int s, away;
                s = int'(st[i]);
                away = (i == 0) ? -1 : 1;
                m_wall[i] = (m_x[i] == 0 || m_x[i] == RL) ? 1 : 0;
                m_col[i] = col_tab[s];
                if (frame_tick) begin
                    if ((s == 9 || s == 10) && !(m_prev[i] == 9 || m_prev[i] == 10)) begin
                        m_left[i] = KB;
                        m_spd[i] = (s == 9) ? 4 : 2;
                    end
                    if (m_left[i] > 0) begin
                        m_x[i] = to_wall(m_x[i] + away * m_spd[i]);
                        m_left[i]--;
                    end else if (s == 2) begin
                        m_x[i] = fwd_step(i, m_x[i], int'(opp[i]));
                    end else if (s == 1) begin
                        m_x[i] = to_wall(m_x[i] + away * 2);
                    end
                    m_prev[i] = s;
                    m_kb[i] = (m_left[i] > 0) ? 1 : 0;
                end
            end
        end
    end

    // Every-cycle compare against the model
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("model_x%0d", i), int'(sx[i]), m_x[i]);
            check($sformatf("model_y%0d", i), int'(sy[i]), 180);
            check($sformatf("model_col%0d", i), int'(col[i]), m_col[i]);
            check($sformatf("model_kb%0d", i), int'(kb[i]), m_kb[i]);
            check($sformatf("model_wall%0d", i), int'(wall[i]), m_wall[i]);
        end
    end

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    int exp_a [9] = '{562, 564, 566, 568, 570, 572, 574, 576, 576};

    initial begin
        st[0] = 4'd0; st[1] = 4'd0; opp[0] = 10'd170; opp[1] = 10'd0;
        repeat (2) @(negedge clk);
        check("reset_x0", int'(sx[0]), 100);
        check("reset_x1", int'(sx[1]), 476);
        check("reset_y", int'(sy[0]), 180);
        check("reset_col", int'(col[0]), 0);
        check("reset_kb", int'(kb[1]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Forward into the opponent, then pacing with no ticks
        st[0] = 4'd2;
        tick(); check("fwd_1", int'(sx[0]), 103);
        tick(); check("fwd_2", int'(sx[0]), 106);
        tick(); check("fwd_abut", int'(sx[0]), 106);
        repeat (10) @(negedge clk);
        check("no_tick_hold", int'(sx[0]), 106);

        // Walk back onto the left wall
        opp[0] = 10'd600;
        tick(); check("fwd_free", int'(sx[0]), 109);
        st[0] = 4'd1;
        repeat (53) tick();
        check("back_to_3", int'(sx[0]), 3);
        tick(); check("back_1", int'(sx[0]), 1);
        tick(); check("back_0", int'(sx[0]), 0);
        check("wall_lag", int'(wall[0]), 0);
        @(negedge clk);
        check("wall_set", int'(wall[0]), 1);
        tick(); check("back_hold0", int'(sx[0]), 0);

        // Hitstun knockback from x=300
        opp[0] = 10'd700; st[0] = 4'd2;
        repeat (100) tick();
        check("walk_300", int'(sx[0]), 300);
        st[0] = 4'd9;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("hit_x_%0d", k), int'(sx[0]), (k <= 6) ? 300 - 4 * k : 276);
            check($sformatf("hit_kb_%0d", k), int'(kb[0]), (k <= 5) ? 1 : 0);
        end

        // Colour table spot checks
        st[0] = 4'd9;  @(negedge clk); check("col_hit", int'(col[0]), 'h88);
        st[0] = 4'd10; @(negedge clk); check("col_block", int'(col[0]), 'h0F);
        st[0] = 4'd3;  @(negedge clk); check("col_start", int'(col[0]), 'hFC);
        st[0] = 4'd13; @(negedge clk); check("col_other", int'(col[0]), 'hFF);
        st[0] = 4'd0;

        // Mirrored blockstun with restart against the right wall
        st[1] = 4'd1;
        repeat (42) tick();
        check("mir_560", int'(sx[1]), 560);
        for (int k = 0; k < 9; k++) begin
            st[1] = (k == 4) ? 4'd0 : 4'd10;
            tick();
            check($sformatf("mir_kb_x_%0d", k), int'(sx[1]), exp_a[k]);
        end
        check("mir_kb_active", int'(kb[1]), 1);

        // Asynchronous reset mid-knockback
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_x1", int'(sx[1]), 476);
        check("areset_x0", int'(sx[0]), 100);
        check("areset_kb", int'(kb[1]), 0);
        check("areset_col", int'(col[1]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised play
        for (int n = 0; n < 3000; n++) begin
            frame_tick = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 2; i++) begin
                int r, o;
                r = $urandom_range(0, 9);
                st[i] = (r < 3) ? 4'd2 : (r < 5) ? 4'd1 : (r < 6) ? 4'd9 :
                        (r < 7) ? 4'd10 : 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 0) o = $urandom_range(0, 1023);
                else o = m_x[i] + ((i == 0) ? 64 : -64) + $urandom_range(0, 12) - 6;
                o = (o < 0) ? 0 : ((o > 1023) ? 1023 : o);
                opp[i] = 10'(o);
            end
            @(negedge clk);
        end
        frame_tick = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
